spi_sub: RTL and testbench

//  SPI subordinate (responder), mode 0 (CPOL=0, CPHA=0), MSB first; the far end of spi_main.
//  - Oversamples sclk/cs/mosi in the local clk domain.
//  - Deserialises mosi into rx_data; serialises a preloaded tx byte onto miso.
//  - Sits between an SPI pin interface and a local register or command block.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_sub.sv | 158 +++++++++++++++
 tb/tb_spi_sub.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI subordinate: mode constant, FSM state type, default width.
package spi_pkg;

    localparam logic [1:0]  SPI_MODE0  = 2'b00; // {CPOL, CPHA}
    localparam int unsigned SPI_DATA_W = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } spi_sub_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with single-cycle rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_sub.sv
// SPI mode 0 subordinate, MSB first: oversampled pins, rx deserialiser, tx serialiser with a
// single-entry tx buffer and back-to-back byte support while cs stays low.
module spi_sub
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W      = SPI_DATA_W,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              underrun
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(sclk),
        .dout(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(cs),
        .dout(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    spi_sub_state_t    state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              miso_q, miso_d;
    logic              reload;
    logic [DATA_W-1:0] reload_byte;
    logic [DATA_W-1:0] rx_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        miso_d      = miso_q;
        reload      = 1'b0;
        reload_byte = tx_full_q ? tx_buf_q : TX_IDLE;
        rx_next     = {rx_shift_q[DATA_W-2:0], mosi_s};

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                    miso_d    = reload_byte[DATA_W-1];
                end
            end
            SHIFT: begin
                // cs edges take priority over any coincident sclk edge
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        reload     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    // bit_cnt==0 here means a byte just closed: present the reloaded MSB unshifted
                    if (bit_cnt_q == '0) begin
                        miso_d = tx_shift_q[DATA_W-1];
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[DATA_W-2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (reload) begin
            tx_shift_d = reload_byte;
            underrun_d = ~tx_full_q;
            tx_full_d  = 1'b0;
        end

        if (tx_load) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end
    end

    assign miso     = miso_q;
    assign tx_ready = ~tx_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == SHIFT);
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_sub.sv
// Scoreboard bench for spi_sub: stimulus pushes expected rx bytes and miso bytes into queues,
// monitors pop and compare when rx_valid pulses or a full byte has been clocked out on miso.
module tb_spi_sub;

    localparam int PH   = 8;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset, sclk, cs, mosi, miso;
    logic [7:0] tx_data;
    logic       tx_load, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, underrun;

    int total = 0;
    int bad   = 0;
    int ur_cnt = 0;
    int ur0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];

    spi_sub #(.DATA_W(8), .SYNC_STAGES(SYNC), .TX_IDLE(8'h00)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
    endtask

    // Optionally pulse tx_load in the exact cycle the byte-closing rise is acted upon.
    task automatic send_bits(input logic [7:0] b, input int n, input bit hook,
                             input logic [7:0] hb);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            wait_clk(PH);
            sclk = 1'b1;
            if (hook && i == 0) begin
                wait_clk(SYNC);
                tx_data = hb;
                tx_load = 1'b1;
                wait_clk(1);
                tx_load = 1'b0;
                check("reload_cycle_rx_valid", rx_valid, 1);
                check("tx_ready_after_reload_load", tx_ready, 0);
                wait_clk(PH - SYNC - 1);
            end else begin
                wait_clk(PH);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8, 1'b0, 8'h00);
    endtask

    task automatic start_cs();
        cs = 1'b0;
        wait_clk(PH);
    endtask

    task automatic end_cs();
        wait_clk(PH);
        cs = 1'b1;
        wait_clk(PH);
    endtask

    // rx scoreboard and underrun counter
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (underrun === 1'b1) ur_cnt++;
            if (rx_valid === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_byte", rx_data, e);
                end
            end
        end
    end

    // miso scoreboard: the initiator's view, sampled on sclk rise while cs is low
    initial begin
        int n;
        logic [7:0] sh;
        logic [7:0] e;
        n  = 0;
        sh = '0;
        forever begin
            @(posedge sclk or posedge cs);
            if (cs === 1'b1) begin
                n = 0;
            end else begin
                sh = {sh[6:0], miso};
                n++;
                if (n == 8) begin
                    n = 0;
                    if (exp_miso.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL miso_unexpected: got %0h expected none", sh);
                    end else begin
                        e = exp_miso.pop_front();
                        check("miso_byte", sh, e);
                    end
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        cs      = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        wait_clk(3);
        check("rst_miso", miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0;
        wait_clk(4);

        // 1: preloaded A5 out, 3C in
        load_tx(8'hA5);
        check("t1_tx_ready_loaded", tx_ready, 0);
        ur0 = ur_cnt;
        exp_miso.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        start_cs();
        check("t1_busy", busy, 1);
        check("t1_tx_ready_consumed", tx_ready, 1);
        send_byte(8'h3C);
        end_cs();
        check("t1_busy_idle", busy, 0);
        check("t1_miso_idle", miso, 0);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_underrun_cnt", ur_cnt - ur0, 1); // empty buffer at byte-close reload
        check("t1_rx_drained", exp_rx.size(), 0);

        // 2: nothing loaded -> TX_IDLE and underrun at cs fall
        ur0 = ur_cnt;
        exp_miso.push_back(8'h00);
        exp_rx.push_back(8'h5A);
        start_cs();
        check("t2_underrun_at_start", ur_cnt - ur0, 1);
        send_byte(8'h5A);
        end_cs();
        check("t2_underrun_cnt", ur_cnt - ur0, 2);
        check("t2_rx_data", rx_data, 8'h5A);

        // 3: two bytes under one cs, F0 loaded during byte 1
        ur0 = ur_cnt;
        exp_miso.push_back(8'h00);
        exp_miso.push_back(8'hF0);
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
        start_cs();
        load_tx(8'hF0);
        send_byte(8'h11);
        send_byte(8'h22);
        end_cs();
        check("t3_rx_data", rx_data, 8'h22);
        check("t3_underrun_cnt", ur_cnt - ur0, 2);
        check("t3_tx_ready", tx_ready, 1);
        check("t3_rx_drained", exp_rx.size(), 0);

        // 4: partial byte discarded
        start_cs();
        send_bits(8'hFF, 5, 1'b0, 8'h00);
        end_cs();
        check("t4_rx_data_held", rx_data, 8'h22);
        check("t4_busy", busy, 0);
        check("t4_miso", miso, 0);
        check("t4_rx_drained", exp_rx.size(), 0);

        // 5: reset mid-byte, then a clean byte
        load_tx(8'h55);
        start_cs();
        send_bits(8'hA5, 3, 1'b0, 8'h00);
        cs    = 1'b1;
        reset = 1'b1;
        wait_clk(1);
        check("t5_rst_miso", miso, 0);
        check("t5_rst_tx_ready", tx_ready, 1);
        check("t5_rst_rx_data", rx_data, 0);
        check("t5_rst_rx_valid", rx_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_underrun", underrun, 0);
        reset = 1'b0;
        wait_clk(PH);
        load_tx(8'hC3);
        exp_miso.push_back(8'hC3);
        exp_rx.push_back(8'h7E);
        start_cs();
        send_byte(8'h7E);
        end_cs();
        check("t5_rx_data", rx_data, 8'h7E);

        // 6: load coincident with byte-close reload
        ur0 = ur_cnt;
        load_tx(8'h81);
        exp_miso.push_back(8'h81);
        exp_miso.push_back(8'h66);
        exp_miso.push_back(8'h42);
        exp_rx.push_back(8'h0F);
        exp_rx.push_back(8'hF5);
        exp_rx.push_back(8'h3A);
        start_cs();
        load_tx(8'h66);
        send_bits(8'h0F, 8, 1'b1, 8'h42);
        send_byte(8'hF5);
        send_byte(8'h3A);
        end_cs();
        check("t6_rx_data", rx_data, 8'h3A);
        check("t6_tx_ready", tx_ready, 1);
        check("t6_underrun_cnt", ur_cnt - ur0, 1);

        check("final_rx_drained", exp_rx.size(), 0);
        check("final_miso_drained", exp_miso.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
